// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester (fetch/data) arbiter onto a single memory port
module mem_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  output logic        d_gnt_o,
  output logic        d_rvalid_o,
  output logic [31:0] d_rdata_o,
  output logic        d_err_o,
  output logic        mem_en_o,
  output logic        mem_we_o,
  output logic [29:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  localparam int unsigned CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIMIT = CW'(STARVE_MAX);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  owner_t        owner_q;
  owner_t        owner_d;
  logic [CW-1:0] starve_cnt;
  logic [CW-1:0] starve_nxt;
  logic          err_q;
  logic          fetch_wins;
  logic          d_misalign;
  logic          d_access;
  logic          d_store;
  logic          unused_if_lsbs;

  // Fetch address low bits are never checked; only the word address is used.
  assign unused_if_lsbs = ^if_addr_i[1:0];

  // Arbitration and grants: data wins unless fetch is starved or data is idle.
  always_comb begin
    fetch_wins = if_req_i && (!d_req_i || (starve_cnt == STARVE_LIMIT));
    if_gnt_o   = !rst && fetch_wins;
    d_gnt_o    = !rst && d_req_i && !fetch_wins;
    d_misalign = (d_addr_i[1:0] != 2'b00);
    d_access   = d_gnt_o && !d_misalign;
    d_store    = d_access && d_we_i;
  end

  // Memory port driven from the winner; everything zero when nothing is granted.
  always_comb begin
    mem_en_o    = if_gnt_o || d_access;
    mem_we_o    = d_store;
    mem_addr_o  = 30'd0;
    mem_wdata_o = 32'd0;
    if (if_gnt_o) begin
      mem_addr_o = if_addr_i[31:2];
    end else if (d_gnt_o) begin
      mem_addr_o = d_addr_i[31:2];
    end
    if (d_store) begin
      mem_wdata_o = d_wdata_i;
    end
  end

  // Starvation counter next value: counts denied fetch cycles, saturating.
  always_comb begin
    starve_nxt = starve_cnt;
    if (!if_req_i || if_gnt_o) begin
      starve_nxt = '0;
    end else if (starve_cnt != STARVE_LIMIT) begin
      starve_nxt = starve_cnt + 1'b1;
    end
  end

  // Owner of the outstanding read, reloaded every cycle from this cycle's grant.
  always_comb begin
    owner_d = OWN_NONE;
    if (if_gnt_o) begin
      owner_d = OWN_IF;
    end else if (d_access && !d_we_i) begin
      owner_d = OWN_D;
    end
  end

  // State registers: owner, starvation counter and misalignment error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q    <= OWN_NONE;
      starve_cnt <= '0;
      err_q      <= 1'b0;
    end else begin
      owner_q    <= owner_d;
      starve_cnt <= starve_nxt;
      err_q      <= d_gnt_o && d_misalign;
    end
  end

  // Responses steered to the owner; reset hides a read that was in flight.
  always_comb begin
    if_rvalid_o = !rst && (owner_q == OWN_IF);
    d_rvalid_o  = !rst && (owner_q == OWN_D);
    d_err_o     = !rst && err_q;
    if_rdata_o  = if_rvalid_o ? mem_rdata_i : 32'd0;
    d_rdata_o   = d_rvalid_o ? mem_rdata_i : 32'd0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_gnt_o;
  logic        if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        d_req_i;
  logic        d_we_i;
  logic [31:0] d_addr_i;
  logic [31:0] d_wdata_i;
  logic        d_gnt_o;
  logic        d_rvalid_o;
  logic [31:0] d_rdata_o;
  logic        d_err_o;
  logic        mem_en_o;
  logic        mem_we_o;
  logic [29:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;

  int checks   = 0;
  int failures = 0;

  mem_arbiter #(.STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o), .d_err_o(d_err_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    if_req_i    = 1'b0;
    if_addr_i   = 32'd0;
    d_req_i     = 1'b0;
    d_we_i      = 1'b0;
    d_addr_i    = 32'd0;
    d_wdata_i   = 32'd0;
    mem_rdata_i = 32'd0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    if_req_i = 1'b1; if_addr_i = 32'h100;
    d_req_i = 1'b1; d_addr_i = 32'h200;
    mem_rdata_i = 32'hA5A5A5A5;
    #1;
    checks++; if (if_gnt_o !== 1'b0) begin failures++; $display("FAIL reset_if_gnt got %b exp 0", if_gnt_o); end
    checks++; if (d_gnt_o !== 1'b0) begin failures++; $display("FAIL reset_d_gnt got %b exp 0", d_gnt_o); end
    checks++; if (mem_en_o !== 1'b0) begin failures++; $display("FAIL reset_mem_en got %b exp 0", mem_en_o); end
    @(negedge clk);
    #1;
    checks++; if (if_rvalid_o !== 1'b0) begin failures++; $display("FAIL reset_if_rvalid got %b exp 0", if_rvalid_o); end
    checks++; if (d_rvalid_o !== 1'b0) begin failures++; $display("FAIL reset_d_rvalid got %b exp 0", d_rvalid_o); end
    checks++; if (d_err_o !== 1'b0) begin failures++; $display("FAIL reset_d_err got %b exp 0", d_err_o); end
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    mem_rdata_i = 32'hA5A5A5A5;
    #1;
    checks++; if (if_rvalid_o !== 1'b0) begin failures++; $display("FAIL post_reset_if_rvalid got %b exp 0", if_rvalid_o); end
    checks++; if (d_rvalid_o !== 1'b0) begin failures++; $display("FAIL post_reset_d_rvalid got %b exp 0", d_rvalid_o); end
    checks++; if (if_rdata_o !== 32'd0) begin failures++; $display("FAIL post_reset_if_rdata got %h exp 0", if_rdata_o); end
    checks++; if (mem_addr_o !== 30'd0) begin failures++; $display("FAIL idle_mem_addr got %h exp 0", mem_addr_o); end
    checks++; if (mem_we_o !== 1'b0) begin failures++; $display("FAIL idle_mem_we got %b exp 0", mem_we_o); end
    mem_rdata_i = 32'd0;
  endtask

  task automatic test_fetch_only();
    @(negedge clk);
    idle_inputs();
    if_req_i = 1'b1; if_addr_i = 32'h100;
    #1;
    checks++; if (if_gnt_o !== 1'b1) begin failures++; $display("FAIL fetch_gnt got %b exp 1", if_gnt_o); end
    checks++; if (d_gnt_o !== 1'b0) begin failures++; $display("FAIL fetch_d_gnt got %b exp 0", d_gnt_o); end
    checks++; if (mem_en_o !== 1'b1) begin failures++; $display("FAIL fetch_mem_en got %b exp 1", mem_en_o); end
    checks++; if (mem_addr_o !== 30'h40) begin failures++; $display("FAIL fetch_mem_addr got %h exp 40", mem_addr_o); end
    @(negedge clk);
    idle_inputs();
    mem_rdata_i = 32'hDEADBEEF;
    #1;
    checks++; if (if_rvalid_o !== 1'b1) begin failures++; $display("FAIL fetch_rvalid got %b exp 1", if_rvalid_o); end
    checks++; if (if_rdata_o !== 32'hDEADBEEF) begin failures++; $display("FAIL fetch_rdata got %h exp deadbeef", if_rdata_o); end
    checks++; if (d_rvalid_o !== 1'b0) begin failures++; $display("FAIL fetch_d_rvalid got %b exp 0", d_rvalid_o); end
    checks++; if (d_rdata_o !== 32'd0) begin failures++; $display("FAIL fetch_d_rdata got %h exp 0", d_rdata_o); end
    @(negedge clk);
    #1;
    checks++; if (if_rvalid_o !== 1'b0) begin failures++; $display("FAIL fetch_rvalid_one_cycle got %b exp 0", if_rvalid_o); end
    mem_rdata_i = 32'd0;
  endtask

  task automatic test_simultaneous();
    @(negedge clk);
    idle_inputs();
    if_req_i = 1'b1; if_addr_i = 32'h100;
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h200;
    #1;
    checks++; if (d_gnt_o !== 1'b1) begin failures++; $display("FAIL simul_d_gnt got %b exp 1", d_gnt_o); end
    checks++; if (if_gnt_o !== 1'b0) begin failures++; $display("FAIL simul_if_gnt got %b exp 0", if_gnt_o); end
    checks++; if (mem_addr_o !== 30'h80) begin failures++; $display("FAIL simul_mem_addr got %h exp 80", mem_addr_o); end
    @(negedge clk);
    idle_inputs();
    mem_rdata_i = 32'hCAFEF00D;
    #1;
    checks++; if (d_rvalid_o !== 1'b1) begin failures++; $display("FAIL simul_d_rvalid got %b exp 1", d_rvalid_o); end
    checks++; if (d_rdata_o !== 32'hCAFEF00D) begin failures++; $display("FAIL simul_d_rdata got %h exp cafef00d", d_rdata_o); end
    checks++; if (if_rvalid_o !== 1'b0) begin failures++; $display("FAIL simul_if_rvalid got %b exp 0", if_rvalid_o); end
    checks++; if (if_rdata_o !== 32'd0) begin failures++; $display("FAIL simul_if_rdata got %h exp 0", if_rdata_o); end
    mem_rdata_i = 32'd0;
  endtask

  // Both requesting continuously: D,D,D,D,IF repeating, responses one cycle later.
  task automatic test_back_to_back();
    logic exp_if;
    logic prev_if = 1'b0;
    logic prev_d  = 1'b0;
    @(negedge clk);
    idle_inputs();
    for (int i = 0; i < 11; i++) begin
      if (i > 0) @(negedge clk);
      if (i < 10) begin
        if_req_i = 1'b1; if_addr_i = 32'h400 + 32'(i * 4);
        d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h800 + 32'(i * 4);
      end else begin
        if_req_i = 1'b0; d_req_i = 1'b0;
      end
      mem_rdata_i = 32'h1000 + 32'(i);
      #1;
      exp_if = (i < 10) && ((i % 5) == 4);
      checks++; if (if_gnt_o !== exp_if) begin failures++; $display("FAIL starve_if_gnt[%0d] got %b exp %b", i, if_gnt_o, exp_if); end
      checks++; if (d_gnt_o !== ((i < 10) && !exp_if)) begin failures++; $display("FAIL starve_d_gnt[%0d] got %b exp %b", i, d_gnt_o, (i < 10) && !exp_if); end
      checks++; if (if_rvalid_o !== prev_if) begin failures++; $display("FAIL b2b_if_rvalid[%0d] got %b exp %b", i, if_rvalid_o, prev_if); end
      checks++; if (d_rvalid_o !== prev_d) begin failures++; $display("FAIL b2b_d_rvalid[%0d] got %b exp %b", i, d_rvalid_o, prev_d); end
      if (prev_d) begin
        checks++; if (d_rdata_o !== 32'h1000 + 32'(i)) begin failures++; $display("FAIL b2b_d_rdata[%0d] got %h exp %h", i, d_rdata_o, 32'h1000 + 32'(i)); end
      end
      prev_if = exp_if;
      prev_d  = (i < 10) && !exp_if;
    end
    mem_rdata_i = 32'd0;
  endtask

  task automatic test_store_load();
    @(negedge clk);
    idle_inputs();
    d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h10; d_wdata_i = 32'h12345678;
    #1;
    checks++; if (mem_we_o !== 1'b1) begin failures++; $display("FAIL store_mem_we got %b exp 1", mem_we_o); end
    checks++; if (mem_en_o !== 1'b1) begin failures++; $display("FAIL store_mem_en got %b exp 1", mem_en_o); end
    checks++; if (mem_wdata_o !== 32'h12345678) begin failures++; $display("FAIL store_wdata got %h exp 12345678", mem_wdata_o); end
    checks++; if (mem_addr_o !== 30'h4) begin failures++; $display("FAIL store_mem_addr got %h exp 4", mem_addr_o); end
    @(negedge clk);
    d_we_i = 1'b0; d_wdata_i = 32'hFFFFFFFF;
    #1;
    checks++; if (d_rvalid_o !== 1'b0) begin failures++; $display("FAIL store_no_rvalid got %b exp 0", d_rvalid_o); end
    checks++; if (mem_we_o !== 1'b0) begin failures++; $display("FAIL load_mem_we got %b exp 0", mem_we_o); end
    checks++; if (mem_wdata_o !== 32'd0) begin failures++; $display("FAIL load_wdata got %h exp 0", mem_wdata_o); end
    checks++; if (mem_en_o !== 1'b1) begin failures++; $display("FAIL load_mem_en got %b exp 1", mem_en_o); end
    @(negedge clk);
    idle_inputs();
    mem_rdata_i = 32'h12345678;
    #1;
    checks++; if (d_rvalid_o !== 1'b1) begin failures++; $display("FAIL load_d_rvalid got %b exp 1", d_rvalid_o); end
    checks++; if (d_rdata_o !== 32'h12345678) begin failures++; $display("FAIL load_d_rdata got %h exp 12345678", d_rdata_o); end
    mem_rdata_i = 32'd0;
  endtask

  task automatic test_misaligned();
    @(negedge clk);
    idle_inputs();
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h203;
    #1;
    checks++; if (d_gnt_o !== 1'b1) begin failures++; $display("FAIL misalign_d_gnt got %b exp 1", d_gnt_o); end
    checks++; if (mem_en_o !== 1'b0) begin failures++; $display("FAIL misalign_mem_en got %b exp 0", mem_en_o); end
    checks++; if (d_err_o !== 1'b0) begin failures++; $display("FAIL misalign_err_early got %b exp 0", d_err_o); end
    @(negedge clk);
    idle_inputs();
    mem_rdata_i = 32'h55;
    #1;
    checks++; if (d_err_o !== 1'b1) begin failures++; $display("FAIL misalign_err got %b exp 1", d_err_o); end
    checks++; if (d_rvalid_o !== 1'b0) begin failures++; $display("FAIL misalign_rvalid got %b exp 0", d_rvalid_o); end
    checks++; if (d_rdata_o !== 32'd0) begin failures++; $display("FAIL misalign_rdata got %h exp 0", d_rdata_o); end
    @(negedge clk);
    #1;
    checks++; if (d_err_o !== 1'b0) begin failures++; $display("FAIL misalign_err_pulse got %b exp 0", d_err_o); end
    mem_rdata_i = 32'd0;
  endtask

  task automatic test_reset_mid_read();
    @(negedge clk);
    idle_inputs();
    if_req_i = 1'b1; if_addr_i = 32'h300;
    #1;
    checks++; if (if_gnt_o !== 1'b1) begin failures++; $display("FAIL rstmid_if_gnt got %b exp 1", if_gnt_o); end
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    mem_rdata_i = 32'h11111111;
    #1;
    checks++; if (if_rvalid_o !== 1'b0) begin failures++; $display("FAIL rstmid_rvalid_in_reset got %b exp 0", if_rvalid_o); end
    checks++; if (if_rdata_o !== 32'd0) begin failures++; $display("FAIL rstmid_rdata_in_reset got %h exp 0", if_rdata_o); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (if_rvalid_o !== 1'b0) begin failures++; $display("FAIL rstmid_rvalid_after got %b exp 0", if_rvalid_o); end
    // Fetch requests alone stalls nothing, then contention must show a fresh counter.
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      if_req_i = 1'b1; if_addr_i = 32'h500;
      d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h600;
      #1;
      checks++; if (if_gnt_o !== (i == 4)) begin failures++; $display("FAIL rstmid_starve[%0d] got %b exp %b", i, if_gnt_o, i == 4); end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_fetch_only();
    test_simultaneous();
    test_back_to_back();
    test_store_load();
    test_misaligned();
    test_reset_mid_read();
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
